// File: rtl/gpu_pkg.sv
// -----------------------------------------------------------------------------
// gpu_pkg
// Shared definitions for the core pipeline: scheduler state encodings,
// instruction-fetcher state encodings, program-memory width defaults and a
// saturating-counter helper.
// -----------------------------------------------------------------------------
package gpu_pkg;

    localparam int DEFAULT_ADDR_BITS = 8;
    localparam int DEFAULT_DATA_BITS = 16;
    localparam int COUNT_BITS        = 16;

    // Scheduler (core) state encodings; only the states the fetcher reacts to
    // plus the terminal state are named here.
    typedef enum logic [3:0] {
        CORE_IDLE   = 4'd0,
        CORE_FETCH  = 4'd1,
        CORE_DECODE = 4'd2,
        CORE_DONE   = 4'd8
    } core_state_e;

    // Instruction-fetcher FSM encodings (visible on the fetcher_state port).
    typedef enum logic [1:0] {
        FETCHER_IDLE     = 2'b00,
        FETCHER_FETCHING = 2'b01,
        FETCHER_FETCHED  = 2'b10
    } fetcher_state_e;

    // Increment that sticks at all-ones instead of wrapping.
    function automatic logic [COUNT_BITS-1:0] sat_inc(input logic [COUNT_BITS-1:0] value);
        if (value == {COUNT_BITS{1'b1}}) begin
            sat_inc = value;
        end else begin
            sat_inc = value + COUNT_BITS'(1);
        end
    endfunction

endpackage

// File: rtl/instr_fetcher_if.sv
// -----------------------------------------------------------------------------
// instr_fetcher_if
// Program-memory read channel (valid/ready).
//   mem_read_valid   : request from fetcher
//   mem_read_address : request address, stable while valid
//   mem_read_ready   : memory returns data this cycle
//   mem_read_data    : returned instruction
// master = fetcher side, slave = memory-controller side.
// -----------------------------------------------------------------------------
interface instr_fetcher_if import gpu_pkg::*; #(
    parameter int ADDR_BITS = DEFAULT_ADDR_BITS,
    parameter int DATA_BITS = DEFAULT_DATA_BITS
);
    logic                 mem_read_valid;
    logic [ADDR_BITS-1:0] mem_read_address;
    logic                 mem_read_ready;
    logic [DATA_BITS-1:0] mem_read_data;

    modport master (
        output mem_read_valid,
        output mem_read_address,
        input  mem_read_ready,
        input  mem_read_data
    );

    modport slave (
        input  mem_read_valid,
        input  mem_read_address,
        output mem_read_ready,
        output mem_read_data
    );
endinterface

// File: rtl/instr_fetcher_fetch_buffer.sv
// -----------------------------------------------------------------------------
// fetch_buffer
// Direct-mapped instruction buffer: valid/tag/data per entry.
//   clk, reset : clock, synchronous active-high reset (clears valid bits)
//   flush      : clear all valid bits next cycle; wins over a write
//   lookup_pc  : PC looked up combinationally -> hit, data
//   wr_en, wr_pc, wr_data : synchronous fill port
// -----------------------------------------------------------------------------
module fetch_buffer #(
    parameter int ADDR_BITS = 8,
    parameter int DATA_BITS = 16,
    parameter int ENTRIES   = 4
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 flush,
    input  logic [ADDR_BITS-1:0] lookup_pc,
    output logic                 hit,
    output logic [DATA_BITS-1:0] data,
    input  logic                 wr_en,
    input  logic [ADDR_BITS-1:0] wr_pc,
    input  logic [DATA_BITS-1:0] wr_data
);
    localparam int IDX_BITS = $clog2(ENTRIES);
    localparam int TAG_BITS = ADDR_BITS - IDX_BITS;

    logic [ENTRIES-1:0]   valid_r;
    logic [TAG_BITS-1:0]  tag_r  [ENTRIES];
    logic [DATA_BITS-1:0] data_r [ENTRIES];

    logic [IDX_BITS-1:0] lookup_idx_s;
    logic [TAG_BITS-1:0] lookup_tag_s;
    logic [IDX_BITS-1:0] wr_idx_s;
    logic [TAG_BITS-1:0] wr_tag_s;

    assign lookup_idx_s = lookup_pc[IDX_BITS-1:0];
    assign lookup_tag_s = lookup_pc[ADDR_BITS-1:IDX_BITS];
    assign wr_idx_s     = wr_pc[IDX_BITS-1:0];
    assign wr_tag_s     = wr_pc[ADDR_BITS-1:IDX_BITS];

    // Combinational lookup against the current (pre-flush) contents.
    always_comb begin
        hit  = valid_r[lookup_idx_s] && (tag_r[lookup_idx_s] == lookup_tag_s);
        data = data_r[lookup_idx_s];
    end

    // Valid bits: reset and flush clear everything; flush suppresses a fill.
    always_ff @(posedge clk) begin
        if (reset) begin
            valid_r <= '0;
        end else if (flush) begin
            valid_r <= '0;
        end else if (wr_en) begin
            valid_r[wr_idx_s] <= 1'b1;
        end else begin
            valid_r <= valid_r;
        end
    end

    // Tag/data storage; contents are meaningless while the valid bit is clear.
    always_ff @(posedge clk) begin
        if (wr_en && !flush) begin
            tag_r[wr_idx_s]  <= wr_tag_s;
            data_r[wr_idx_s] <= wr_data;
        end
    end
endmodule

// File: rtl/instr_fetcher.sv
// -----------------------------------------------------------------------------
// instr_fetcher
// Per-core fetch stage. On core_state==FETCH it returns the instruction at
// current_pc, from the buffer (1-cycle hit) or from program memory (miss).
//   clk, reset     : clock, synchronous active-high reset
//   core_state     : scheduler state (FETCH starts a fetch, DECODE releases it)
//   current_pc     : PC to fetch (sampled only in IDLE)
//   flush          : invalidate the instruction buffer
//   mem            : program-memory read channel (master side)
//   instruction    : fetched instruction, held until the next fetch completes
//   request_ready  : instruction valid, to scheduler
//   fetcher_state  : IDLE / FETCHING / FETCHED
//   hit_count, miss_count : saturating buffer statistics
// -----------------------------------------------------------------------------
module instr_fetcher import gpu_pkg::*; #(
    parameter int PROGRAM_MEM_ADDR_BITS = DEFAULT_ADDR_BITS,
    parameter int PROGRAM_MEM_DATA_BITS = DEFAULT_DATA_BITS,
    parameter int BUF_ENTRIES           = 4
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic [3:0]                       core_state,
    input  logic [PROGRAM_MEM_ADDR_BITS-1:0] current_pc,
    input  logic                             flush,
    instr_fetcher_if.master                  mem,
    output logic [PROGRAM_MEM_DATA_BITS-1:0] instruction,
    output logic                             request_ready,
    output logic [1:0]                       fetcher_state,
    output logic [COUNT_BITS-1:0]            hit_count,
    output logic [COUNT_BITS-1:0]            miss_count
);
    fetcher_state_e state_r, next_state_s;

    logic                             buf_hit_s;
    logic [PROGRAM_MEM_DATA_BITS-1:0] buf_data_s;
    logic                             handshake_s;
    logic                             fill_en_s;

    logic                             mem_valid_r,  mem_valid_s;
    logic [PROGRAM_MEM_ADDR_BITS-1:0] mem_addr_r,   mem_addr_s;
    logic [PROGRAM_MEM_DATA_BITS-1:0] instr_r,      instr_s;
    logic                             req_r,        req_s;
    logic [COUNT_BITS-1:0]            hit_count_r,  hit_count_s;
    logic [COUNT_BITS-1:0]            miss_count_r, miss_count_s;

    // Ready is only meaningful while our own request is outstanding.
    assign handshake_s = mem_valid_r && mem.mem_read_ready;
    assign fill_en_s   = (state_r == FETCHER_FETCHING) && handshake_s;

    fetch_buffer #(
        .ADDR_BITS (PROGRAM_MEM_ADDR_BITS),
        .DATA_BITS (PROGRAM_MEM_DATA_BITS),
        .ENTRIES   (BUF_ENTRIES)
    ) u_fetch_buffer (
        .clk       (clk),
        .reset     (reset),
        .flush     (flush),
        .lookup_pc (current_pc),
        .hit       (buf_hit_s),
        .data      (buf_data_s),
        .wr_en     (fill_en_s),
        .wr_pc     (mem_addr_r),
        .wr_data   (mem.mem_read_data)
    );

    // FSM state register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r <= FETCHER_IDLE;
        end else begin
            state_r <= next_state_s;
        end
    end

    // FSM next-state logic.
    always_comb begin
        next_state_s = state_r;
        case (state_r)
            FETCHER_IDLE: begin
                if (core_state == CORE_FETCH) begin
                    next_state_s = buf_hit_s ? FETCHER_FETCHED : FETCHER_FETCHING;
                end else begin
                    next_state_s = FETCHER_IDLE;
                end
            end
            FETCHER_FETCHING: begin
                if (handshake_s) begin
                    next_state_s = FETCHER_FETCHED;
                end else begin
                    next_state_s = FETCHER_FETCHING;
                end
            end
            FETCHER_FETCHED: begin
                if (core_state == CORE_DECODE) begin
                    next_state_s = FETCHER_IDLE;
                end else begin
                    next_state_s = FETCHER_FETCHED;
                end
            end
            default: next_state_s = FETCHER_IDLE;
        endcase
    end

    // FSM output logic: next values of the registered outputs and counters.
    always_comb begin
        mem_valid_s  = mem_valid_r;
        mem_addr_s   = mem_addr_r;
        instr_s      = instr_r;
        req_s        = req_r;
        hit_count_s  = hit_count_r;
        miss_count_s = miss_count_r;
        case (state_r)
            FETCHER_IDLE: begin
                if (core_state == CORE_FETCH) begin
                    if (buf_hit_s) begin
                        instr_s     = buf_data_s;
                        req_s       = 1'b1;
                        hit_count_s = sat_inc(hit_count_r);
                    end else begin
                        mem_valid_s  = 1'b1;
                        mem_addr_s   = current_pc;
                        miss_count_s = sat_inc(miss_count_r);
                    end
                end else begin
                    req_s = 1'b0;
                end
            end
            FETCHER_FETCHING: begin
                if (handshake_s) begin
                    instr_s     = mem.mem_read_data;
                    mem_valid_s = 1'b0;
                    req_s       = 1'b1;
                end else begin
                    mem_valid_s = 1'b1;
                end
            end
            FETCHER_FETCHED: begin
                if (core_state == CORE_DECODE) begin
                    req_s = 1'b0;
                end else begin
                    req_s = 1'b1;
                end
            end
            default: begin
                mem_valid_s = 1'b0;
                req_s       = 1'b0;
            end
        endcase
    end

    // Output and counter registers; reset also drops any in-flight request.
    always_ff @(posedge clk) begin
        if (reset) begin
            mem_valid_r  <= 1'b0;
            mem_addr_r   <= '0;
            instr_r      <= '0;
            req_r        <= 1'b0;
            hit_count_r  <= '0;
            miss_count_r <= '0;
        end else begin
            mem_valid_r  <= mem_valid_s;
            mem_addr_r   <= mem_addr_s;
            instr_r      <= instr_s;
            req_r        <= req_s;
            hit_count_r  <= hit_count_s;
            miss_count_r <= miss_count_s;
        end
    end

    assign mem.mem_read_valid   = mem_valid_r;
    assign mem.mem_read_address = mem_addr_r;
    assign instruction          = instr_r;
    assign request_ready        = req_r;
    assign fetcher_state        = state_r;
    assign hit_count            = hit_count_r;
    assign miss_count           = miss_count_r;
endmodule

// File: doc/instr_fetcher.md
Name: instr_fetcher

Overview:
- Per-core instruction fetch stage that sits directly upstream of the core scheduler.
- When the scheduler is in FETCH, it obtains the 16-bit instruction at current_pc and raises request_ready. The scheduler uses request_ready to advance to DECODE.
- Contains a small direct-mapped instruction buffer so repeated PCs (loops) skip the program-memory round trip.
- Talks to the program-memory controller over a valid/ready read channel.

Parameters:
- PROGRAM_MEM_ADDR_BITS, 8, PC / program-memory address width.
- PROGRAM_MEM_DATA_BITS, 16, instruction width.
- BUF_ENTRIES, 4, instruction-buffer entries; power of two, >= 2.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- core_state  in  4  scheduler state (IDLE=0, FETCH=1, DECODE=2, ... DONE=8)
- current_pc  in  PROGRAM_MEM_ADDR_BITS  PC to fetch
- flush  in  1  invalidate all buffer entries (pulsed at kernel launch)
- mem_read_valid  out  1  program-memory read request
- mem_read_address  out  PROGRAM_MEM_ADDR_BITS  request address
- mem_read_ready  in  1  read data valid this cycle
- mem_read_data  in  PROGRAM_MEM_DATA_BITS  returned instruction
- instruction  out  PROGRAM_MEM_DATA_BITS  fetched instruction, to decoder
- request_ready  out  1  instruction valid, to scheduler
- fetcher_state  out  2  IDLE=00, FETCHING=01, FETCHED=10
- hit_count  out  16  saturating buffer-hit counter
- miss_count  out  16  saturating buffer-miss counter

Behaviour:
- Reset: all of the following are 0, fetcher_state=IDLE, and all buffer valid bits are cleared:
  - mem_read_valid, mem_read_address
  - instruction, request_ready
  - hit_count, miss_count
- Buffer addressing: index = current_pc[log2(BUF_ENTRIES)-1:0]; tag = remaining upper PC bits. Each entry holds valid, tag and data.
- IDLE, core_state==FETCH, hit:
  - instruction <= entry data, request_ready <= 1, go FETCHED.
  - Latency is 1 cycle; no memory request is made.
  - hit_count++ (saturates at 0xFFFF).
- IDLE, core_state==FETCH, miss:
  - mem_read_valid <= 1, mem_read_address <= current_pc, go FETCHING.
  - miss_count++ (saturates at 0xFFFF).
- FETCHING:
  - mem_read_valid and mem_read_address are held stable until the handshake.
  - The handshake is the cycle with mem_read_valid && mem_read_ready. On that cycle:
    - instruction <= mem_read_data
    - the entry at index is written (valid=1, tag, data), evicting any previous occupant
    - mem_read_valid <= 0, request_ready <= 1, go FETCHED
  - mem_read_ready is ignored whenever mem_read_valid=0.
  - Any memory latency >= 1 cycle is allowed.
- FETCHED:
  - request_ready and instruction are held.
  - When core_state==DECODE: request_ready <= 0, go IDLE. instruction keeps its value until the next fetch completes.
- Other core_state values in IDLE: no action.
- flush:
  - Clears all valid bits the next cycle.
  - Does not abort an in-flight fetch. If flush coincides with a fill, flush wins and the entry is not written; instruction and request_ready still update normally.
  - flush in the same cycle as an IDLE lookup: the lookup uses pre-flush contents.
- Reset mid-FETCHING: the request is dropped immediately (mem_read_valid=0). The memory controller must tolerate an abandoned request.
- A current_pc change while FETCHING or FETCHED is ignored; the latched request address is used.
- Counters: count only on the IDLE->FETCHED and IDLE->FETCHING transitions. They are never cleared by flush.

Decomposition:
- gpu_pkg (shared package) holds:
  - core_state encodings (IDLE..DONE, 4-bit)
  - fetcher_state encodings (2-bit)
  - PROGRAM_MEM_* width defaults
- Sub-module fetch_buffer: direct-mapped valid/tag/data array with combinational lookup (hit, data), a synchronous write port, and a synchronous flush (flush beats write).
- instr_fetcher contains the FSM, the memory handshake and the counters.

Test Plan:
- Cold miss: PC=0x05, core_state=FETCH, memory returns 0x3A5C after 3 cycles.
  - Required: mem_read_valid high with address 0x05 for those 3 cycles; request_ready rises the cycle after the handshake; instruction=0x3A5C; miss_count=1.
- Hit: after the cold miss, DECODE then FETCH again at PC=0x05.
  - Required: request_ready one cycle after FETCH; mem_read_valid stays 0; hit_count=1.
- Conflict: fetch 0x05 then 0x09 (same index, BUF_ENTRIES=4), then 0x05 again.
  - Required: three memory requests; miss_count=3.
- Flush: flush pulse after 0x05 is buffered, then fetch 0x05.
  - Required: memory request issued (miss).
  - Variant: flush on the handshake cycle, then refetch. Required: a miss again, while instruction still updates on the flushed fill.
- Reset mid-fetch: reset while FETCHING.
  - Required: next cycle mem_read_valid=0, fetcher_state=IDLE, request_ready=0, counters=0.
  - A subsequent fetch of the same PC misses.
- Saturation: force 65537 hits.
  - Required: hit_count stays 0xFFFF.
